// File: rtl/fpmul_pkg.sv
// Shared definitions for the bfloat16 multiplier issue/collect path.
package fpmul_pkg;

  localparam int BF16_W    = 16;
  localparam int FPMUL_LAT = 3;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } issue_state_t;

endpackage

// File: rtl/fpmul_issue_if.sv
// Bundles the operand stream, multiplier hookup, result stream and flush/error lines.
interface fpmul_issue_if #(
  parameter int W = 16
);

  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_a;
  logic [W-1:0] s_b;

  logic [W-1:0] mul_x1;
  logic [W-1:0] mul_x2;
  logic         mul_en;
  logic [W-1:0] mul_y;
  logic         mul_ready;

  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;

  logic         flush;
  logic         flush_done;
  logic         err;

  // The issue controller sits on this side.
  modport slave (
    input  s_valid, s_a, s_b, mul_y, mul_ready, m_ready, flush,
    output s_ready, mul_x1, mul_x2, mul_en, m_valid, m_data, flush_done, err
  );

  // Producer, multiplier and consumer environment.
  modport master (
    output s_valid, s_a, s_b, mul_y, mul_ready, m_ready, flush,
    input  s_ready, mul_x1, mul_x2, mul_en, m_valid, m_data, flush_done, err
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered head-of-queue output; any depth >= 1.
module sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [W-1:0]               rd_data,
  output logic                       overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] rd_ptr_inc;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [W-1:0]  head_reg;
  logic [W-1:0]  head_next;
  logic          push_ok;
  logic          pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty      = (count_reg == '0);
  assign full       = (count_reg == CW'(DEPTH));
  assign count      = count_reg;
  assign rd_data    = head_reg;
  assign pop_ok     = pop & ~empty;
  // A full FIFO still takes a push when a pop frees the slot in the same cycle.
  assign push_ok    = push & (~full | pop_ok);
  assign overflow   = push & full & ~pop_ok;
  assign rd_ptr_inc = ptr_inc(rd_ptr_reg);

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // The next head comes from the write port when that entry is being written now.
  always_comb begin
    head_next = head_reg;
    if (pop_ok) begin
      if (count_reg == CW'(1)) begin
        if (push_ok) head_next = push_data;
      end else begin
        head_next = mem[rd_ptr_inc];
      end
    end else if (empty && push_ok) begin
      head_next = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_inc;
      count_reg <= count_next;
      head_reg  <= head_next;
    end
  end

endmodule

// File: rtl/fpmul_issue.sv
// Credit-based issue/collect controller in front of the bfloat16 fpmul pipeline.
module fpmul_issue
  import fpmul_pkg::*;
#(
  parameter int LAT       = FPMUL_LAT,
  parameter int RES_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  fpmul_issue_if.slave bus
);

  localparam int IW = $clog2(LAT + 1);
  localparam int CW = $clog2(RES_DEPTH + 1);
  localparam int SW = ((IW > CW) ? IW : CW) + 1;

  issue_state_t   state_reg;
  issue_state_t   state_next;
  logic [IW-1:0]  inflight_reg;
  logic [IW-1:0]  inflight_next;
  logic           err_reg;
  logic [CW-1:0]  occupancy;
  logic [SW-1:0]  credit_used;
  logic           has_credit;
  logic           issue;
  logic           spurious;
  logic           collect;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_overflow;
  logic [BF16_W-1:0] fifo_data;

  // Credit uses only registered counts, so s_ready never looks at m_ready.
  assign credit_used = SW'(inflight_reg) + SW'(occupancy);
  assign has_credit  = (credit_used < SW'(RES_DEPTH));

  assign bus.s_ready = (state_reg == RUN) & ~bus.flush & has_credit & ~rst;
  assign issue       = bus.s_valid & bus.s_ready;
  assign bus.mul_en  = issue;
  assign bus.mul_x1  = bus.s_a;
  assign bus.mul_x2  = bus.s_b;

  // A product strobe with nothing outstanding belongs to no issued op: flag it, keep it out.
  assign spurious = bus.mul_ready & (inflight_reg == '0);
  assign collect  = bus.mul_ready & ~spurious;

  always_comb begin
    inflight_next = inflight_reg;
    case ({issue, collect})
      2'b10:   inflight_next = inflight_reg + 1'b1;
      2'b01:   inflight_next = inflight_reg - 1'b1;
      default: inflight_next = inflight_reg;
    endcase
  end

  sync_fifo #(
    .W     (BF16_W),
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (collect),
    .push_data (bus.mul_y),
    .pop       (bus.m_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (occupancy),
    .rd_data   (fifo_data),
    .overflow  (fifo_overflow)
  );

  assign bus.m_valid    = ~fifo_empty;
  assign bus.m_data     = fifo_data;
  assign bus.err        = err_reg;
  assign bus.flush_done = (state_reg == DONE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (bus.flush) state_next = DRAIN;
      DRAIN:   if ((inflight_reg == '0) && fifo_empty) state_next = DONE;
      DONE:    state_next = bus.flush ? DRAIN : RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RUN;
      inflight_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= inflight_next;
      err_reg      <= err_reg | spurious | fifo_overflow;
    end
  end

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_fpmul_issue.sv
// Self-checking bench: fpmul stand-in pipeline plus credit/scoreboard model.
module tb_fpmul_issue;
  import fpmul_pkg::*;

  localparam int LAT   = FPMUL_LAT;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpmul_issue_if #(.W(BF16_W)) bus ();

  fpmul_issue #(
    .LAT       (LAT),
    .RES_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int outstanding = 0;
  int n_acc = 0;
  int n_pop = 0;
  logic inject = 1'b0;

  // Truncating bfloat16 multiply for normal operands; used only to generate products.
  function automatic logic [15:0] bf_mul(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] m;
    logic [6:0]  f;
    logic        s;
    int          e;
    s = a[15] ^ b[15];
    if (a[14:7] == 8'd0 || b[14:7] == 8'd0) return {s, 15'd0};
    m = {8'd0, 1'b1, a[6:0]} * {8'd0, 1'b1, b[6:0]};
    e = int'(a[14:7]) + int'(b[14:7]) - 127;
    if (m[15]) begin
      e++;
      f = m[14:8];
    end else begin
      f = m[13:7];
    end
    if (e < 1) return {s, 15'd0};
    if (e > 254) return {s, 8'hFF, 7'd0};
    return {s, 8'(e), f};
  endfunction

  // fpmul stand-in: LAT-stage pipeline, cleared by the shared reset.
  logic [15:0] pipe_y [LAT];
  logic        pipe_v [LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_y[i] <= 16'd0;
      end
    end else begin
      pipe_v[0] <= bus.mul_en;
      pipe_y[0] <= bf_mul(bus.mul_x1, bus.mul_x2);
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_y[i] <= pipe_y[i-1];
      end
    end
  end
  assign bus.mul_ready = pipe_v[LAT-1] | inject;
  assign bus.mul_y     = pipe_y[LAT-1];

  function automatic logic [15:0] rand_bf16();
    return {1'($urandom_range(0, 1)), 8'(120 + $urandom_range(0, 15)), 7'($urandom_range(0, 127))};
  endfunction

  // Bookkeeping for one clock: record the handshakes about to happen, then advance.
  task automatic cycle();
    #1;
    if (bus.s_valid && bus.s_ready) begin
      exp_q.push_back(bf_mul(bus.s_a, bus.s_b));
      outstanding++;
      n_acc++;
    end
    if (bus.m_valid && bus.m_ready) begin
      got_q.push_back(bus.m_data);
      outstanding--;
      n_pop++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 60 && outstanding > 0; i++) cycle();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    got_q.delete();
    outstanding = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready got=%b want=0", bus.s_ready); end
    if (bus.mul_en !== 1'b0) begin failures++; $display("FAIL reset_mul_en got=%b want=0", bus.mul_en); end
    if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b want=0", bus.m_valid); end
    if (bus.m_data !== 16'h0) begin failures++; $display("FAIL reset_m_data got=%h want=0000", bus.m_data); end
    if (bus.flush_done !== 1'b0) begin failures++; $display("FAIL reset_flush_done got=%b want=0", bus.flush_done); end
    if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", bus.err); end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL reset_release_s_ready got=%b want=1", bus.s_ready); end
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_single();
    bus.s_a = 16'h3F80; bus.s_b = 16'h4000; bus.s_valid = 1'b1; bus.m_ready = 1'b0;
    cycle();
    bus.s_valid = 1'b0;
    cycle(); cycle();
    checks++;
    if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid cycle3 got=%b want=0", bus.m_valid); end
    cycle();
    checks += 3;
    if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL single_valid cycle4 got=%b want=1", bus.m_valid); end
    if (bus.m_data !== 16'h4000) begin failures++; $display("FAIL single_data got=%h want=4000", bus.m_data); end
    if (bus.err !== 1'b0) begin failures++; $display("FAIL single_err got=%b want=0", bus.err); end
    drain();
    $display("test_single data=%h", bus.m_data);
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_backpressure();
    logic [15:0] tab [8];
    int k, acc0, bad;
    tab = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080, 16'h40A0, 16'h40C0, 16'h40E0, 16'h4100};
    k = 0; acc0 = n_acc;
    bus.m_ready = 1'b0; bus.s_valid = 1'b1; bus.s_a = 16'h3F80; bus.s_b = tab[0];
    for (int i = 0; i < 10; i++) begin
      cycle();
      k = n_acc - acc0;
      if (k < 8) bus.s_b = tab[k];
    end
    #1;
    checks += 2;
    if (k != DEPTH) begin failures++; $display("FAIL bp_accept_count got=%0d want=%0d", k, DEPTH); end
    if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL bp_s_ready_low got=%b want=0", bus.s_ready); end
    bus.m_ready = 1'b1;
    for (int i = 0; i < 80 && (k < 8 || outstanding > 0); i++) begin
      bus.s_valid = (k < 8);
      cycle();
      k = n_acc - acc0;
      if (k < 8) bus.s_b = tab[k];
    end
    bus.s_valid = 1'b0;
    bad = (got_q.size() != 8) ? 1 : 0;
    if (bad == 0) foreach (got_q[i]) if (got_q[i] !== tab[i]) bad = 1;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL bp_results got_n=%0d want_n=8 first=%h want_first=3f80", got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'h0); end
    $display("test_backpressure results=%0d", got_q.size());
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_full_concurrency();
    int bad, rdy_bad, over;
    bus.m_ready = 1'b0; bus.s_valid = 1'b1;
    rdy_bad = 0; over = 0;
    for (int i = 0; i < 48; i++) begin
      if (i == 8) bus.m_ready = 1'b1;
      bus.s_a = rand_bf16(); bus.s_b = rand_bf16();
      #1;
      if (bus.s_ready !== (outstanding < DEPTH)) rdy_bad++;
      if (outstanding > DEPTH) over++;
      cycle();
    end
    drain();
    checks += 3;
    if (rdy_bad != 0) begin failures++; $display("FAIL conc_s_ready cycles_wrong=%0d want=0", rdy_bad); end
    if (over != 0 || bus.err !== 1'b0) begin failures++; $display("FAIL conc_err err=%b over=%0d want err=0 over=0", bus.err, over); end
    bad = (got_q.size() != exp_q.size()) ? 1 : 0;
    if (bad == 0) foreach (got_q[i]) if (got_q[i] !== exp_q[i]) bad = 1;
    if (bad != 0) begin failures++; $display("FAIL conc_order got_n=%0d want_n=%0d", got_q.size(), exp_q.size()); end
    $display("test_full_concurrency results=%0d", got_q.size());
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_flush();
    int acc0, pulses, last_pop, done_at, pop0, bad;
    bus.m_ready = 1'b0;
    bus.s_a = rand_bf16(); bus.s_b = rand_bf16(); bus.s_valid = 1'b1;
    cycle();
    bus.s_valid = 1'b0;
    repeat (4) cycle();
    bus.s_valid = 1'b1;
    bus.s_a = rand_bf16(); cycle();
    bus.s_a = rand_bf16(); cycle();
    bus.flush = 1'b1;
    #1;
    checks += 2;
    if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL flush_s_ready got=%b want=0", bus.s_ready); end
    if (outstanding != 3) begin failures++; $display("FAIL flush_setup outstanding=%0d want=3", outstanding); end
    bus.m_ready = 1'b1;
    acc0 = n_acc; pulses = 0; last_pop = -1; done_at = -1;
    for (int i = 0; i < 30; i++) begin
      pop0 = n_pop;
      cycle();
      if (n_pop != pop0) last_pop = i;
      if (bus.flush_done === 1'b1) begin
        pulses++;
        if (done_at < 0) done_at = i;
        checks++;
        if (bus.m_valid !== 1'b0 || outstanding != 0) begin
          failures++; $display("FAIL flush_done_early m_valid=%b outstanding=%0d want 0/0", bus.m_valid, outstanding);
        end
        bus.flush = 1'b0;
        bus.s_valid = 1'b0;
      end
    end
    #1;
    checks += 4;
    if (pulses != 1) begin failures++; $display("FAIL flush_pulses got=%0d want=1", pulses); end
    if (done_at <= last_pop) begin failures++; $display("FAIL flush_order done_at=%0d last_pop=%0d", done_at, last_pop); end
    if (n_acc != acc0) begin failures++; $display("FAIL flush_accepts got=%0d want=0", n_acc - acc0); end
    if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL flush_resume_s_ready got=%b want=1", bus.s_ready); end
    bad = (got_q.size() != 3) ? 1 : 0;
    if (bad == 0) foreach (got_q[i]) if (got_q[i] !== exp_q[i]) bad = 1;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL flush_results got_n=%0d want_n=3", got_q.size()); end
    @(negedge clk);
    $display("test_flush pulses=%0d done_at=%0d last_pop=%0d", pulses, done_at, last_pop);
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_error();
    bus.s_valid = 1'b0; bus.m_ready = 1'b1;
    inject = 1'b1;
    cycle();
    inject = 1'b0;
    #1;
    checks += 3;
    if (bus.err !== 1'b1) begin failures++; $display("FAIL err_set got=%b want=1", bus.err); end
    if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL err_no_push m_valid=%b want=0", bus.m_valid); end
    if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL err_credit s_ready=%b want=1", bus.s_ready); end
    bus.s_a = rand_bf16(); bus.s_b = rand_bf16(); bus.s_valid = 1'b1;
    cycle();
    drain();
    checks += 2;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      failures++; $display("FAIL err_followup got_n=%0d got=%h want=%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'h0, exp_q[0]);
    end
    if (bus.err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b want=1", bus.err); end
    $display("test_error err=%b", bus.err);
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_midstream();
    bus.m_ready = 1'b0; bus.s_valid = 1'b1;
    bus.s_a = rand_bf16(); bus.s_b = rand_bf16(); cycle();
    bus.s_a = rand_bf16(); cycle();
    bus.s_valid = 1'b0;
    repeat (5) cycle();
    bus.s_valid = 1'b1;
    bus.s_a = rand_bf16(); cycle();
    bus.s_a = rand_bf16(); cycle();
    bus.s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL mid_s_ready got=%b want=0", bus.s_ready); end
    if (bus.mul_en !== 1'b0) begin failures++; $display("FAIL mid_mul_en got=%b want=0", bus.mul_en); end
    if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL mid_m_valid got=%b want=0", bus.m_valid); end
    if (bus.m_data !== 16'h0) begin failures++; $display("FAIL mid_m_data got=%h want=0000", bus.m_data); end
    if (bus.flush_done !== 1'b0) begin failures++; $display("FAIL mid_flush_done got=%b want=0", bus.flush_done); end
    if (bus.err !== 1'b0) begin failures++; $display("FAIL mid_err got=%b want=0", bus.err); end
    rst = 1'b0;
    exp_q.delete(); got_q.delete(); outstanding = 0;
    bus.m_ready = 1'b1;
    repeat (10) cycle();
    #1;
    checks += 2;
    if (got_q.size() != 0) begin failures++; $display("FAIL mid_stale got_n=%0d want=0", got_q.size()); end
    if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL mid_s_ready_after got=%b want=1", bus.s_ready); end
    @(negedge clk);
    $display("test_reset_midstream stale=%0d", got_q.size());
  endtask

  task automatic test_random();
    int rdy_bad, en_bad, bad;
    rdy_bad = 0; en_bad = 0;
    for (int i = 0; i < 400; i++) begin
      bus.s_valid = ($urandom_range(0, 3) != 0);
      bus.m_ready = ($urandom_range(0, 1) != 0);
      bus.s_a = rand_bf16(); bus.s_b = rand_bf16();
      #1;
      if (bus.s_ready !== (outstanding < DEPTH)) rdy_bad++;
      if (bus.mul_en !== (bus.s_valid && (outstanding < DEPTH))) en_bad++;
      cycle();
    end
    drain();
    checks += 4;
    if (rdy_bad != 0) begin failures++; $display("FAIL rand_s_ready cycles_wrong=%0d want=0", rdy_bad); end
    if (en_bad != 0) begin failures++; $display("FAIL rand_mul_en cycles_wrong=%0d want=0", en_bad); end
    if (outstanding != 0 || bus.err !== 1'b0) begin failures++; $display("FAIL rand_drain outstanding=%0d err=%b want 0/0", outstanding, bus.err); end
    bad = (got_q.size() != exp_q.size()) ? 1 : 0;
    if (bad == 0) foreach (got_q[i]) if (got_q[i] !== exp_q[i]) bad = 1;
    if (bad != 0) begin failures++; $display("FAIL rand_results got_n=%0d want_n=%0d", got_q.size(), exp_q.size()); end
    $display("test_random results=%0d", got_q.size());
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    bus.s_valid = 1'b0; bus.s_a = 16'h0; bus.s_b = 16'h0;
    bus.m_ready = 1'b0; bus.flush = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_full_concurrency();
    test_flush();
    test_random();
    test_error();
    test_reset_midstream();
    apply_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
